// File: rtl/motoro3_line_step_scheduler.sv
// Sequencer for the motor-3 line-parameter calculator: latches the PWM request, sweeps
// lcStep from 0 to STEP_LAST and emits one registered table write per settled step.
module motoro3_line_step_scheduler #(
    parameter logic [3:0]  STEP_LAST  = 4'd11,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic        clkIn,
    input  logic        rstIn,
    input  logic        startIn,
    input  logic        abortIn,
    input  logic        autoEnIn,
    input  logic [11:0] pwmLenWantIn,
    input  logic [11:0] pwmMinMaskIn,
    output logic [11:0] lcPwmLenWant,
    output logic [11:0] lcPwmMinMask,
    output logic [3:0]  lcStep,
    input  logic [15:0] slLenIn,
    input  logic [15:0] plLenIn,
    output logic        tblWe,
    output logic [3:0]  tblAddr,
    output logic [15:0] tblSlLen,
    output logic [15:0] tblPlLen,
    output logic        busy,
    output logic        doneP,
    output logic        errZero
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [3:0] CNT_RELOAD = 4'(SETTLE_CYC - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [11:0] r_pwm_len_want;
    logic [11:0] r_pwm_min_mask;
    logic [3:0]  r_lc_step;
    logic        r_tbl_we;
    logic [3:0]  r_tbl_addr;
    logic [15:0] r_tbl_sl_len;
    logic [15:0] r_tbl_pl_len;
    logic        r_busy;
    logic        r_done_p;
    logic        r_err_zero;

    logic [3:0]  w_cnt_nxt;
    logic [11:0] w_pwm_len_want_nxt;
    logic [11:0] w_pwm_min_mask_nxt;
    logic [3:0]  w_lc_step_nxt;
    logic        w_tbl_we_nxt;
    logic [3:0]  w_tbl_addr_nxt;
    logic [15:0] w_tbl_sl_len_nxt;
    logic [15:0] w_tbl_pl_len_nxt;
    logic        w_err_zero_nxt;
    logic        w_auto_chg;
    logic        w_abort;
    logic        w_last_step;

    assign w_auto_chg  = autoEnIn && ((pwmLenWantIn != r_pwm_len_want) ||
                                      (pwmMinMaskIn != r_pwm_min_mask));
    assign w_abort     = abortIn && (r_state != S_IDLE);
    assign w_last_step = (r_lc_step == STEP_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (!abortIn && (startIn || w_auto_chg)) w_state_nxt = S_LOAD;
            S_LOAD:   w_state_nxt = S_SETTLE;
            S_SETTLE: if (r_cnt == 4'd0) w_state_nxt = S_WRITE;
            S_WRITE:  w_state_nxt = w_last_step ? S_DONE : S_SETTLE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
        if (w_abort) w_state_nxt = S_IDLE;
    end

    // NOTE: every comb output gets a hold/default value first, so no path can infer a latch.
    always_comb begin
        w_cnt_nxt          = r_cnt;
        w_pwm_len_want_nxt = r_pwm_len_want;
        w_pwm_min_mask_nxt = r_pwm_min_mask;
        w_lc_step_nxt      = r_lc_step;
        w_tbl_we_nxt       = 1'b0;
        w_tbl_addr_nxt     = r_tbl_addr;
        w_tbl_sl_len_nxt   = r_tbl_sl_len;
        w_tbl_pl_len_nxt   = r_tbl_pl_len;
        w_err_zero_nxt     = r_err_zero;
        if (w_abort) begin
            // Cancelled sweep: only the step index is returned; latched pair and errZero survive.
            w_lc_step_nxt = 4'd0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    w_pwm_len_want_nxt = pwmLenWantIn;
                    w_pwm_min_mask_nxt = pwmMinMaskIn;
                    w_lc_step_nxt      = 4'd0;
                    w_cnt_nxt          = CNT_RELOAD;
                    w_err_zero_nxt     = 1'b0;
                end
                S_SETTLE: begin
                    if (r_cnt != 4'd0) begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end else begin
                        w_tbl_sl_len_nxt = slLenIn;
                        w_tbl_pl_len_nxt = plLenIn;
                        w_tbl_addr_nxt   = r_lc_step;
                        w_tbl_we_nxt     = 1'b1;
                        if (plLenIn == 16'd0) w_err_zero_nxt = 1'b1;
                    end
                end
                S_WRITE: begin
                    if (!w_last_step) begin
                        w_lc_step_nxt = r_lc_step + 4'd1;
                        w_cnt_nxt     = CNT_RELOAD;
                    end
                end
                S_DONE: w_lc_step_nxt = 4'd0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            r_cnt          <= 4'd0;
            r_pwm_len_want <= 12'd0;
            r_pwm_min_mask <= 12'd0;
            r_lc_step      <= 4'd0;
            r_tbl_we       <= 1'b0;
            r_tbl_addr     <= 4'd0;
            r_tbl_sl_len   <= 16'd0;
            r_tbl_pl_len   <= 16'd0;
            r_busy         <= 1'b0;
            r_done_p       <= 1'b0;
            r_err_zero     <= 1'b0;
        end else begin
            r_cnt          <= w_cnt_nxt;
            r_pwm_len_want <= w_pwm_len_want_nxt;
            r_pwm_min_mask <= w_pwm_min_mask_nxt;
            r_lc_step      <= w_lc_step_nxt;
            r_tbl_we       <= w_tbl_we_nxt;
            r_tbl_addr     <= w_tbl_addr_nxt;
            r_tbl_sl_len   <= w_tbl_sl_len_nxt;
            r_tbl_pl_len   <= w_tbl_pl_len_nxt;
            r_busy         <= (w_state_nxt != S_IDLE);
            r_done_p       <= (r_state == S_WRITE) && w_last_step && !w_abort;
            r_err_zero     <= w_err_zero_nxt;
        end
    end

    assign lcPwmLenWant = r_pwm_len_want;
    assign lcPwmMinMask = r_pwm_min_mask;
    assign lcStep       = r_lc_step;
    assign tblWe        = r_tbl_we;
    assign tblAddr      = r_tbl_addr;
    assign tblSlLen     = r_tbl_sl_len;
    assign tblPlLen     = r_tbl_pl_len;
    assign busy         = r_busy;
    assign doneP        = r_done_p;
    assign errZero      = r_err_zero;

endmodule

// File: tb/tb_motoro3_line_step_scheduler.sv
// Bench for motoro3_line_step_scheduler: a default instance and a one-step instance,
// each driven by a calculator model, with table writes checked against a scoreboard.
module tb_motoro3_line_step_scheduler;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] sl;
        logic [15:0] pl;
        int          wcyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int c0_a = 0;
    int c0_b = 0;
    int wr_cnt_a = 0;
    int wr_cnt_b = 0;
    int done_cnt_a = 0;
    int done_cnt_b = 0;
    int done_snap = 0;
    logic zero_en = 1'b0;
    exp_t sb_a[$];
    exp_t sb_b[$];

    // Instance A (default parameters)
    logic        start_a = 0, abort_a = 0, auto_a = 0;
    logic [11:0] want_a = 0, mask_a = 0;
    logic [11:0] lc_want_a, lc_mask_a;
    logic [3:0]  lc_step_a, addr_a;
    logic [15:0] sl_a, pl_a, tsl_a, tpl_a;
    logic        we_a, busy_a, done_a, err_a;

    // Instance B (one step, one settle cycle)
    logic        start_b = 0, abort_b = 0, auto_b = 0;
    logic [11:0] want_b = 0, mask_b = 0;
    logic [11:0] lc_want_b, lc_mask_b;
    logic [3:0]  lc_step_b, addr_b;
    logic [15:0] sl_b, pl_b, tsl_b, tpl_b;
    logic        we_b, busy_b, done_b, err_b;

    function automatic logic [15:0] calc_sl(logic [11:0] want, logic [11:0] mask, logic [3:0] step);
        return (16'(want) * (16'(step) + 16'd1)) ^ 16'(mask);
    endfunction

    function automatic logic [15:0] calc_pl(logic [11:0] want, logic [3:0] step, logic zero5);
        if (zero5 && step == 4'd5) return 16'd0;
        return 16'(want) + 16'(step) * 16'd7 + 16'd1;
    endfunction

    assign sl_a = calc_sl(lc_want_a, lc_mask_a, lc_step_a);
    assign pl_a = calc_pl(lc_want_a, lc_step_a, zero_en);
    assign sl_b = calc_sl(lc_want_b, lc_mask_b, lc_step_b);
    assign pl_b = calc_pl(lc_want_b, lc_step_b, 1'b0);

    motoro3_line_step_scheduler u_dut_a (
        .clkIn(clk), .rstIn(rst), .startIn(start_a), .abortIn(abort_a), .autoEnIn(auto_a),
        .pwmLenWantIn(want_a), .pwmMinMaskIn(mask_a),
        .lcPwmLenWant(lc_want_a), .lcPwmMinMask(lc_mask_a), .lcStep(lc_step_a),
        .slLenIn(sl_a), .plLenIn(pl_a),
        .tblWe(we_a), .tblAddr(addr_a), .tblSlLen(tsl_a), .tblPlLen(tpl_a),
        .busy(busy_a), .doneP(done_a), .errZero(err_a)
    );

    motoro3_line_step_scheduler #(.STEP_LAST(4'd0), .SETTLE_CYC(1)) u_dut_b (
        .clkIn(clk), .rstIn(rst), .startIn(start_b), .abortIn(abort_b), .autoEnIn(auto_b),
        .pwmLenWantIn(want_b), .pwmMinMaskIn(mask_b),
        .lcPwmLenWant(lc_want_b), .lcPwmMinMask(lc_mask_b), .lcStep(lc_step_b),
        .slLenIn(sl_b), .plLenIn(pl_b),
        .tblWe(we_b), .tblAddr(addr_b), .tblSlLen(tsl_b), .tblPlLen(tpl_b),
        .busy(busy_b), .doneP(done_b), .errZero(err_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_a(input logic [11:0] want, input logic [11:0] mask, input int last_k, input logic zero5);
        for (int k = 0; k <= last_k; k++)
            sb_a.push_back('{addr: 4'(k), sl: calc_sl(want, mask, 4'(k)),
                             pl: calc_pl(want, 4'(k), zero5), wcyc: 4 + 3 * k});
    endtask

    // Edge 0 is the next rising edge; cycle n then follows edge n-1.
    task automatic arm_a();
        @(posedge clk);
        #1 c0_a = cyc;
    endtask

    task automatic arm_b();
        @(posedge clk);
        #1 c0_b = cyc;
    endtask

    task automatic goto_a(input int n);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (cyc - c0_a + 1 >= n) break;
        end
    endtask

    task automatic goto_b(input int n);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (cyc - c0_b + 1 >= n) break;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (we_a) begin
                wr_cnt_a++;
                if (sb_a.size() == 0) begin
                    check("a_unexpected_we", 32'(we_a), 32'd0);
                end else begin
                    exp_t e;
                    e = sb_a.pop_front();
                    check("a_wr_addr", 32'(addr_a), 32'(e.addr));
                    check("a_wr_sl", 32'(tsl_a), 32'(e.sl));
                    check("a_wr_pl", 32'(tpl_a), 32'(e.pl));
                    check("a_wr_cycle", 32'(cyc - c0_a + 1), 32'(e.wcyc));
                end
            end
            if (we_b) begin
                wr_cnt_b++;
                if (sb_b.size() == 0) begin
                    check("b_unexpected_we", 32'(we_b), 32'd0);
                end else begin
                    exp_t e;
                    e = sb_b.pop_front();
                    check("b_wr_addr", 32'(addr_b), 32'(e.addr));
                    check("b_wr_sl", 32'(tsl_b), 32'(e.sl));
                    check("b_wr_pl", 32'(tpl_b), 32'(e.pl));
                    check("b_wr_cycle", 32'(cyc - c0_b + 1), 32'(e.wcyc));
                end
            end
            if (done_a) done_cnt_a++;
            if (done_b) done_cnt_b++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_snap;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_we", 32'(we_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_step", 32'(lc_step_a), 32'd0);
        check("rst_want", 32'(lc_want_a), 32'd0);
        check("rst_err", 32'(err_a), 32'd0);
        check("rst_tbl_sl", 32'(tsl_a), 32'd0);
        check("rst_b_busy", 32'(busy_b), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Abort beats start in IDLE
        start_a = 1; abort_a = 1;
        repeat (2) @(negedge clk);
        check("start_abort_idle_busy", 32'(busy_a), 32'd0);
        start_a = 0; abort_a = 0;

        // Full default sweep; input change mid-sweep must be ignored
        want_a = 12'h320; mask_a = 12'h00F;
        push_a(12'h320, 12'h00F, 11, 1'b0);
        start_a = 1;
        arm_a();
        goto_a(1);
        check("s1_load_busy", 32'(busy_a), 32'd1);
        start_a = 0;
        goto_a(2);
        check("s1_latched_want", 32'(lc_want_a), 32'h320);
        check("s1_latched_mask", 32'(lc_mask_a), 32'h00F);
        goto_a(10);
        want_a = 12'h777;
        goto_a(20);
        check("s1_want_held", 32'(lc_want_a), 32'h320);
        goto_a(37);
        check("s1_busy37", 32'(busy_a), 32'd1);
        check("s1_done37", 32'(done_a), 32'd0);
        goto_a(38);
        check("s1_done38", 32'(done_a), 32'd1);
        goto_a(39);
        check("s1_busy39", 32'(busy_a), 32'd0);
        check("s1_done39", 32'(done_a), 32'd0);
        check("s1_step39", 32'(lc_step_a), 32'd0);
        check("s1_writes", 32'(wr_cnt_a), 32'd12);
        check("s1_sb_empty", 32'(sb_a.size()), 32'd0);
        check("s1_err", 32'(err_a), 32'd0);

        // Abort at cycle 14
        want_a = 12'h123; mask_a = 12'h0F0;
        push_a(12'h123, 12'h0F0, 3, 1'b0);
        done_snap = done_cnt_a;
        wr_snap = wr_cnt_a;
        start_a = 1;
        arm_a();
        goto_a(1);
        start_a = 0;
        goto_a(14);
        abort_a = 1;
        goto_a(15);
        abort_a = 0;
        check("ab_busy15", 32'(busy_a), 32'd0);
        check("ab_step15", 32'(lc_step_a), 32'd0);
        goto_a(16);
        check("ab_no_we16", 32'(we_a), 32'd0);
        goto_a(45);
        check("ab_no_done", 32'(done_cnt_a), 32'(done_snap));
        check("ab_writes", 32'(wr_cnt_a - wr_snap), 32'd4);
        check("ab_want_kept", 32'(lc_want_a), 32'h123);
        check("ab_sb_empty", 32'(sb_a.size()), 32'd0);

        // plLen == 0 at step 5 sets errZero
        zero_en = 1;
        want_a = 12'h200; mask_a = 12'h001;
        push_a(12'h200, 12'h001, 11, 1'b1);
        start_a = 1;
        arm_a();
        goto_a(1);
        start_a = 0;
        goto_a(18);
        check("ez_err18", 32'(err_a), 32'd0);
        goto_a(19);
        check("ez_err19", 32'(err_a), 32'd1);
        check("ez_pl19", 32'(tpl_a), 32'd0);
        goto_a(39);
        check("ez_err_held", 32'(err_a), 32'd1);
        check("ez_busy39", 32'(busy_a), 32'd0);

        // Next LOAD clears errZero; reset at cycle 20 kills the sweep
        zero_en = 0;
        want_a = 12'h210; mask_a = 12'h002;
        push_a(12'h210, 12'h002, 5, 1'b0);
        start_a = 1;
        arm_a();
        goto_a(1);
        check("clr_err_load", 32'(err_a), 32'd1);
        start_a = 0;
        goto_a(2);
        check("clr_err2", 32'(err_a), 32'd0);
        goto_a(20);
        rst = 1;
        #1;
        check("mr_busy", 32'(busy_a), 32'd0);
        check("mr_step", 32'(lc_step_a), 32'd0);
        check("mr_want", 32'(lc_want_a), 32'd0);
        check("mr_addr", 32'(addr_a), 32'd0);
        check("mr_tpl", 32'(tpl_a), 32'd0);
        @(negedge clk);
        rst = 0;
        check("mr_sb_empty", 32'(sb_a.size()), 32'd0);
        repeat (8) @(negedge clk);
        check("mr_idle_after", 32'(busy_a), 32'd0);

        // Auto start on input change, no restart when unchanged
        want_a = 12'h100; mask_a = 12'h000; auto_a = 1;
        push_a(12'h100, 12'h000, 11, 1'b0);
        arm_a();
        goto_a(1);
        check("au1_busy1", 32'(busy_a), 32'd1);
        goto_a(39);
        check("au1_busy39", 32'(busy_a), 32'd0);
        goto_a(45);
        check("au1_no_restart", 32'(busy_a), 32'd0);
        want_a = 12'h101;
        push_a(12'h101, 12'h000, 11, 1'b0);
        arm_a();
        goto_a(1);
        check("au2_busy1", 32'(busy_a), 32'd1);
        goto_a(2);
        check("au2_want", 32'(lc_want_a), 32'h101);
        goto_a(39);
        check("au2_busy39", 32'(busy_a), 32'd0);
        goto_a(43);
        check("au2_no_restart", 32'(busy_a), 32'd0);
        check("au_sb_empty", 32'(sb_a.size()), 32'd0);
        auto_a = 0;

        // Single-step instance with start held through the sweep
        want_b = 12'h0AB; mask_b = 12'h003;
        sb_b.push_back('{addr: 4'd0, sl: calc_sl(12'h0AB, 12'h003, 4'd0),
                         pl: calc_pl(12'h0AB, 4'd0, 1'b0), wcyc: 3});
        start_b = 1;
        arm_b();
        goto_b(1);
        check("b_busy1", 32'(busy_b), 32'd1);
        goto_b(3);
        check("b_we3", 32'(we_b), 32'd1);
        goto_b(4);
        check("b_done4", 32'(done_b), 32'd1);
        check("b_step4", 32'(lc_step_b), 32'd0);
        start_b = 0;
        goto_b(5);
        check("b_busy5", 32'(busy_b), 32'd0);
        goto_b(8);
        check("b_busy8", 32'(busy_b), 32'd0);
        check("b_writes", 32'(wr_cnt_b), 32'd1);
        check("b_dones", 32'(done_cnt_b), 32'd1);
        check("b_sb_empty", 32'(sb_b.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/motoro3_line_step_scheduler.md
# motoro3_line_step_scheduler

Sequencer for the motor-3 line-parameter calculator. On a start request it latches the wanted PWM length and minimum mask, then sweeps the calculator's `lcStep` input from 0 to `STEP_LAST`. After each step settles, it captures the calculator's `slLen` and `plLen` outputs and streams them as one table write per step. The block sits between the motor control register bank and the per-step line table RAM.

## Interface
- `STEP_LAST`, default 4'd11: last step index swept (0..15).
- `SETTLE_CYC`, default 2: cycles `lcStep` is held before capture (legal 1..15).

- `clkIn` in 1: single clock; all logic rising-edge.
- `rstIn` in 1: asynchronous, active-high reset.
- `startIn` in 1: level, sampled only in IDLE.
- `abortIn` in 1: level; cancels an active sweep.
- `autoEnIn` in 1: when high, an input change in IDLE acts as start.
- `pwmLenWantIn` in 12: wanted PWM length.
- `pwmMinMaskIn` in 12: PWM minimum mask.
- `lcPwmLenWant` out 12: latched value, drives the calculator.
- `lcPwmMinMask` out 12: latched value, drives the calculator.
- `lcStep` out 4: step index to the calculator.
- `slLenIn` in 16: calculator sine length (combinational from `lcStep`).
- `plLenIn` in 16: calculator PWM length.
- `tblWe` out 1: table write strobe, one cycle per step.
- `tblAddr` out 4: table address, equals the step index.
- `tblSlLen` out 16: captured `slLen`.
- `tblPlLen` out 16: captured `plLen`.
- `busy` out 1: state not IDLE.
- `doneP` out 1: one-cycle pulse at sweep completion.
- `errZero` out 1: sticky; some step captured `plLen == 0`.

## Operation
- States: IDLE, LOAD, SETTLE, WRITE, DONE. All outputs are registered.
- Reset: state IDLE; every output 0, including the latched pair, `lcStep`, the table outputs, `errZero`; settle counter 0.
- IDLE → LOAD when `startIn`, or when `autoEnIn` and (`pwmLenWantIn != lcPwmLenWant` or `pwmMinMaskIn != lcPwmMinMask`).
- LOAD (1 cycle):
  - latch `pwmLenWantIn` and `pwmMinMaskIn`;
  - set `lcStep = 0` and the counter to `SETTLE_CYC-1`;
  - clear `errZero`;
  - → SETTLE.
- SETTLE:
  - counter > 0: decrement and stay;
  - counter == 0: register `slLenIn`/`plLenIn` into `tblSlLen`/`tblPlLen`, set `tblAddr = lcStep`, set `tblWe = 1`, → WRITE.
  - If the registered `plLenIn` is 0, `errZero` sets in the same edge.
- WRITE (1 cycle, `tblWe` high):
  - `lcStep == STEP_LAST` → DONE, `lcStep` holds;
  - otherwise `lcStep += 1`, reload the counter, → SETTLE.
- DONE (1 cycle): `doneP = 1`, `lcStep` returns to 0, → IDLE.
- `tblWe` and `doneP` are 0 in every other state. Table data and address outputs hold their last value.
- The latched pair is constant from LOAD to the next LOAD. Input changes during a sweep are ignored until IDLE.
- Abort:
  - `abortIn` in any non-IDLE state: → IDLE at the next edge, `lcStep = 0`, no `tblWe`, no `doneP`.
  - The latched pair and `errZero` keep their values.
  - If `autoEnIn` is high, a new auto-start is evaluated normally from IDLE.
- Abort beats start. Start and abort high together in IDLE: stay IDLE.
- `startIn` while busy is ignored; it is not queued.
- `lcStep` never exceeds `STEP_LAST` and never wraps.

## Timing
- Start sampled at edge 0:
  - LOAD during cycle 1;
  - SETTLE cycles 2..(1+SETTLE_CYC);
  - first WRITE (addr 0) at cycle 2+SETTLE_CYC.
- Step k's WRITE is at cycle 2+SETTLE_CYC+k·(SETTLE_CYC+1).
- Defaults: WRITE addr k at cycle 4+3k, last (addr 11) at cycle 37, `doneP` at cycle 38, IDLE and `busy=0` at cycle 39.
- Capture uses `slLenIn`/`plLenIn` with `lcStep` stable for exactly `SETTLE_CYC` cycles.
- Back-to-back runs: a start held high through DONE is sampled in the IDLE cycle, so LOAD follows after one idle cycle.

## Test plan
- Reset mid-sweep (assert `rstIn` at cycle 20) → all outputs 0 immediately; IDLE after release; no further `tblWe`.
- Default params; `pwmLenWantIn = 0x320`, mask `0x00F`; pulse `startIn` → 12 `tblWe` pulses, addrs 0..11 at cycles 4+3k; data matches a reference model; `doneP` at 38; `busy` low at 39.
- `abortIn` at cycle 14 → no write at cycle 16; `busy` low at 15; `doneP` never asserted; `lcStep = 0`.
- `autoEnIn = 1`, change `pwmLenWantIn` 0x100→0x101 while IDLE → sweep starts the next cycle. With the input unchanged after completion → no restart.
- Calculator model returns `plLen = 0` at step 5 → `errZero` set at the write of addr 5 and held; cleared by the next LOAD.
- `SETTLE_CYC = 1`, `STEP_LAST = 0` → single write at cycle 3, `doneP` at cycle 4. `startIn` held high during the sweep → exactly one sweep until IDLE is reached.
